ps2_reader: RTL
===============

# ps2_reader

Receives device-to-host PS/2 frames (start, 8 data bits LSB first, odd parity, stop) and presents each byte as a one-cycle valid pulse with parity and framing error flags. It sits beside the PS/2 command writer on the same ps2d/ps2c lines. It consumes the device's replies (ACK 0xFA, self-test 0xAA, scan codes) to the commands the writer sends. Bit sampling uses the shared one-cycle falling-edge strobe of the synchronised PS/2 clock.

## Interface
- TIMEOUT_CYCLES, default 50000: clk cycles without a strobe before a partial frame is abandoned (1 ms at 50 MHz).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_en  in  1  receive enable; tie to writer tx_idle; low = writer owns the bus.
- ps2d  in  1  synchronised PS/2 data line (read only, never driven).
- ps2c_neg  in  1  one-cycle strobe on each PS/2 clock falling edge.
- rx_data  out  8  last correctly received byte.
- rx_valid  out  1  one-cycle pulse: rx_data updated with a good byte.
- rx_err_parity  out  1  one-cycle pulse: frame complete, parity wrong.
- rx_err_frame  out  1  one-cycle pulse: stop bit 0 or timeout.
- rx_busy  out  1  high while a frame is in progress (state != IDLE).

## Operation
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on ps2c_neg & rx_en & ps2d==0, go to DATA and clear bit_cnt. A strobe with ps2d==1 is ignored: no error, stay IDLE.
  - DATA: each strobe shifts ps2d into shift[7] (right shift, LSB first) and increments bit_cnt. The strobe that completes the 8th bit moves to PARITY.
  - PARITY: strobe latches ps2d as par_bit; go to STOP.
  - STOP: strobe evaluates the frame and returns to IDLE.
- Evaluation priority:
  - stop==0: rx_err_frame.
  - otherwise ^{shift,par_bit}==0: rx_err_parity.
  - otherwise: rx_valid, and rx_data <= shift.
- Exactly one of the three pulses fires per completed frame.
- rx_data changes only with rx_valid. Bad frames leave it unchanged.
- rx_en low in any non-IDLE state: abort to IDLE next cycle, no pulse.
- rx_en low also blocks frame start.
- bit_cnt is 3 bits; shift is 8 bits. No other arithmetic.

## Timing
- Reset values: rx_data=8'h00; rx_valid, rx_err_parity, rx_err_frame, rx_busy = 0; state=IDLE; bit_cnt=0; timeout counter=0.
- Latency: stop-bit strobe in cycle N gives the result pulse in cycle N+1 (registered), one cycle wide. rx_busy falls in cycle N+1.
- rx_busy rises the cycle after the start strobe.
- Strobes may arrive on consecutive cycles; each is consumed.
- A result pulse and a new start strobe in the same cycle are both handled.
- Reset asserted mid-frame: immediate return to reset values, no pulse after release.

## Configuration
- PS2_READER_TIMEOUT_EN defined:
  - A counter runs only when state != IDLE and clears on every ps2c_neg.
  - When the count reaches TIMEOUT_CYCLES, the FSM returns to IDLE and rx_err_frame pulses for one cycle.
  - A ps2c_neg strobe in the same cycle takes precedence and cancels the timeout.
- Undefined: no counter. A partial frame waits indefinitely; only rx_en low or reset clears it.

## Structure
- Shared package ps2_pkg holds:
  - the rx FSM state enum;
  - PS2_DATA_BITS=8;
  - PS2_FRAME_BITS=11;
  - default timeout constant, also used by the writer's request-to-send timer.
- Sub-module ps2_rx_timeout: a resettable up-counter with a full flag, compiled only under PS2_READER_TIMEOUT_EN. The FSM and shift register stay in ps2_reader.

## Test plan
- Frame 0xFA (bits 0,1,0,1,1,1,1,1), parity 1, stop 1 → single rx_valid, rx_data=0xFA, rx_busy low one cycle after the stop strobe.
- Frame 0xAA with parity 0 → rx_err_parity pulse, rx_valid stays 0, rx_data keeps its previous value (0xFA).
- Frame 0x55 with parity 1 and stop 0 → rx_err_frame only; a following good 0x55 frame with stop 1 → rx_valid, rx_data=0x55.
- rx_en dropped after 4 data bits, then raised, then a full 0xF4 frame → no pulse for the aborted frame, rx_valid with 0xF4 for the second.
- Macro defined, TIMEOUT_CYCLES=100, 5 bits then no strobes → rx_err_frame exactly 100 cycles after the last strobe, rx_busy 0. Without the macro, rx_busy stays 1.
- rst low for 1 cycle during PARITY state → all outputs at reset values, no pulse. A subsequent 0x00 frame (parity 1) → rx_valid with 0x00.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receive FSM states, frame geometry, the default
// partial-frame timeout and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } ps2_rx_state_e;

  localparam int unsigned PS2_DATA_BITS       = 8;
  localparam int unsigned PS2_FRAME_BITS      = 11;
  // 1 ms at 50 MHz; also sizes the writer's request-to-send timer.
  localparam int unsigned PS2_TIMEOUT_DEFAULT = 50000;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_timeout.sv
// Partial-frame watchdog for ps2_reader. Counts clk cycles while i_run is
// high, clears on i_clr (every PS/2 clock strobe) or when not running.
// o_full marks the LIMIT-th consecutive cycle without a strobe.
// Only instantiated when PS2_READER_TIMEOUT_EN is defined.
module ps2_rx_timeout
  import ps2_pkg::*;
#(
  parameter int unsigned LIMIT = PS2_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_clr,
  output logic o_full
);

  localparam int unsigned    CW   = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  // Up-counter of strobe-free busy cycles, saturating at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_full = i_run && (r_cnt == LAST);

endmodule

// File: rtl/ps2_reader.sv
// PS/2 device-to-host frame receiver (start, 8 data LSB first, odd parity,
// stop). Each completed frame yields exactly one registered one-cycle pulse:
// rx_valid, rx_err_parity or rx_err_frame. rx_en low aborts a frame silently.
// Optional macro PS2_READER_TIMEOUT_EN adds a partial-frame timeout of
// TIMEOUT_CYCLES strobe-free cycles that ends in an rx_err_frame pulse.
module ps2_reader
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       ps2d,
  input  logic       ps2c_neg,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err_parity,
  output logic       rx_err_frame,
  output logic       rx_busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ps2_reader: TIMEOUT_CYCLES must be at least 2");
  end

  ps2_rx_state_e r_state;
  ps2_rx_state_e w_state_next;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par_bit;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_err_parity;
  logic          r_err_frame;
  logic          r_busy;

  logic w_tmo;
  logic w_abort;
  logic w_start;
  logic w_cnt_clr;
  logic w_shift_en;
  logic w_par_en;
  logic w_valid;
  logic w_err_parity;
  logic w_err_frame;

`ifdef PS2_READER_TIMEOUT_EN
  ps2_rx_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst),
    .i_run  (r_state != RX_IDLE),
    .i_clr  (ps2c_neg),
    .o_full (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  // rx_en low steals the bus from any in-progress frame; it also gates start.
  assign w_abort = (r_state != RX_IDLE) && !rx_en;
  assign w_start = ps2c_neg && rx_en && !ps2d;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a strobe always wins over a same-cycle timeout.
  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = RX_IDLE;
    end else begin
      case (r_state)
        RX_IDLE: begin
          if (w_start) w_state_next = RX_DATA;
          else         w_state_next = RX_IDLE;
        end
        RX_DATA: begin
          if (ps2c_neg) begin
            if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) w_state_next = RX_PARITY;
            else                                    w_state_next = RX_DATA;
          end else if (w_tmo) begin
            w_state_next = RX_IDLE;
          end else begin
            w_state_next = RX_DATA;
          end
        end
        RX_PARITY: begin
          if (ps2c_neg)   w_state_next = RX_STOP;
          else if (w_tmo) w_state_next = RX_IDLE;
          else            w_state_next = RX_PARITY;
        end
        RX_STOP: begin
          if (ps2c_neg || w_tmo) w_state_next = RX_IDLE;
          else                   w_state_next = RX_STOP;
        end
        default: w_state_next = RX_IDLE;
      endcase
    end
  end

  // Output/control decode: datapath enables and the next result pulse.
  always_comb begin
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_par_en     = 1'b0;
    w_valid      = 1'b0;
    w_err_parity = 1'b0;
    w_err_frame  = 1'b0;
    if (w_abort) begin
      w_cnt_clr = 1'b0;
    end else begin
      case (r_state)
        RX_IDLE: begin
          w_cnt_clr = w_start;
        end
        RX_DATA: begin
          if (ps2c_neg) w_shift_en  = 1'b1;
          else          w_err_frame = w_tmo;
        end
        RX_PARITY: begin
          if (ps2c_neg) w_par_en    = 1'b1;
          else          w_err_frame = w_tmo;
        end
        RX_STOP: begin
          if (ps2c_neg) begin
            if (!ps2d)                              w_err_frame  = 1'b1;
            else if (!ps2_parity_ok(r_shift, r_par_bit)) w_err_parity = 1'b1;
            else                                    w_valid      = 1'b1;
          end else begin
            w_err_frame = w_tmo;
          end
        end
        default: w_cnt_clr = 1'b0;
      endcase
    end
  end

  // Receive datapath: LSB-first shift register, bit counter, parity latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_par_bit <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_bit_cnt <= 3'd0;
      end else if (w_shift_en) begin
        r_shift   <= {ps2d, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
      if (w_par_en) r_par_bit <= ps2d;
      else          r_par_bit <= r_par_bit;
    end
  end

  // Registered outputs; rx_data only moves on a good frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data       <= 8'h00;
      r_valid      <= 1'b0;
      r_err_parity <= 1'b0;
      r_err_frame  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid      <= w_valid;
      r_err_parity <= w_err_parity;
      r_err_frame  <= w_err_frame;
      r_busy       <= (w_state_next != RX_IDLE);
      if (w_valid) r_data <= r_shift;
      else         r_data <= r_data;
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_err_parity = r_err_parity;
  assign rx_err_frame  = r_err_frame;
  assign rx_busy       = r_busy;

endmodule
